// File: rtl/cn_min_accumulator.sv
// Check-node min accumulator: folds 2-input min pairs into row min1/min2/index/sign.
// Optional offset min-sum output stage enabled by defining CNA_OFFSET_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a row
// ACC   | row in progress, cnt_q beats already absorbed
// HOLD  | row result presented, waiting for out_ready
module cn_min_accumulator #(
  parameter int          W      = 6,
  parameter int          NBEATS = 4,
  parameter int          IDXW   = 3,
  parameter logic [W-2:0] OFFSET = (W-1)'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-2:0]    min1_in,
  input  logic [W-2:0]    min2_in,
  input  logic            cp_in,
  input  logic [1:0]      sgn_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-2:0]    min1_out,
  output logic [W-2:0]    min2_out,
  output logic [IDXW-1:0] idx_out,
  output logic            sgn_out
);

  localparam int CNTW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NBEATS - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [W-2:0]      acc1_q, acc1_d;
  logic [W-2:0]      acc2_q, acc2_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              sgn_q, sgn_d;

  logic              accept;
  logic              last_beat;
  logic              beat_sgn;
  logic [IDXW-1:0]   beat_idx;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == LAST);
  assign beat_sgn  = sgn_in[0] ^ sgn_in[1];
  assign beat_idx  = IDXW'({cnt_q, cp_in});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (NBEATS == 1) ? HOLD : ACC;
      ACC:  if (accept && last_beat) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strict less-than everywhere so an equal later minimum never steals the index.
  always_comb begin
    cnt_d  = cnt_q;
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    idx_d  = idx_q;
    sgn_d  = sgn_q;
    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + CNTW'(1);
      if (cnt_q == '0) begin
        acc1_d = min1_in;
        acc2_d = min2_in;
        idx_d  = beat_idx;
        sgn_d  = beat_sgn;
      end else begin
        sgn_d = sgn_q ^ beat_sgn;
        if (min1_in < acc1_q) begin
          acc2_d = (acc1_q < min2_in) ? acc1_q : min2_in;
          acc1_d = min1_in;
          idx_d  = beat_idx;
        end else begin
          acc2_d = (min1_in < acc2_q) ? min1_in : acc2_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      idx_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      idx_q   <= idx_d;
      sgn_q   <= sgn_d;
    end
  end

  assign idx_out = idx_q;
  assign sgn_out = sgn_q;

`ifdef CNA_OFFSET_EN
  assign min1_out = (acc1_q > OFFSET) ? acc1_q - OFFSET : '0;
  assign min2_out = (acc2_q > OFFSET) ? acc2_q - OFFSET : '0;
`else
  assign min1_out = acc1_q;
  assign min2_out = acc2_q;
`endif

endmodule

// File: tb/tb_cn_min_accumulator.sv
// Directed bench for cn_min_accumulator (W=6, NBEATS=4); inputs driven and outputs sampled on negedge.
module tb_cn_min_accumulator;

  localparam int W = 6;
  localparam int NBEATS = 4;
  localparam int IDXW = 3;
  localparam logic [W-2:0] OFF = 5'd1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-2:0]    min1_in, min2_in;
  logic            cp_in;
  logic [1:0]      sgn_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-2:0]    min1_out, min2_out;
  logic [IDXW-1:0] idx_out;
  logic            sgn_out;

  int total = 0;
  int bad   = 0;

  cn_min_accumulator #(.W(W), .NBEATS(NBEATS), .IDXW(IDXW), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .min1_in(min1_in), .min2_in(min2_in), .cp_in(cp_in), .sgn_in(sgn_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .min1_out(min1_out), .min2_out(min2_out), .idx_out(idx_out), .sgn_out(sgn_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output magnitude for an accumulated value in this build.
  function automatic logic [31:0] em(input logic [W-2:0] m);
`ifdef CNA_OFFSET_EN
    return (m > OFF) ? 32'(m - OFF) : 32'd0;
`else
    return 32'(m);
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the beat's accepting posedge.
  task automatic send_beat(input logic [4:0] m1, input logic [4:0] m2,
                           input logic cp, input logic [1:0] s);
    in_valid = 1'b1; min1_in = m1; min2_in = m2; cp_in = cp; sgn_in = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [4:0] m1, input logic [4:0] m2,
                            input logic [2:0] idx, input logic s);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".min1"}, 32'(min1_out), em(m1));
    chk({tag, ".min2"}, 32'(min2_out), em(m2));
    chk({tag, ".idx"},  32'(idx_out), 32'(idx));
    chk({tag, ".sgn"},  32'(sgn_out), 32'(s));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    min1_in = 5'd31; min2_in = 5'd31; cp_in = 1'b1; sgn_in = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.min1", 32'(min1_out), 32'd0);
    chk("rst.min2", 32'(min2_out), 32'd0);
    chk("rst.idx", 32'(idx_out), 32'd0);
    chk("rst.sgn", 32'(sgn_out), 32'd0);

    // Basic row, out_ready held high.
    send_beat(5'd5, 5'd9, 1'b0, 2'b00);
    chk("basic.mid_valid", 32'(out_valid), 32'd0);
    send_beat(5'd3, 5'd7, 1'b1, 2'b01);
    send_beat(5'd4, 5'd6, 1'b0, 2'b00);
    send_beat(5'd8, 5'd12, 1'b1, 2'b10);
    chk_result("basic", 5'd3, 5'd4, 3'd3, 1'b0);
    @(negedge clk);
    chk("basic.ready_back", 32'(in_ready), 32'd1);
    chk("basic.valid_drop", 32'(out_valid), 32'd0);

    // Same row with a 2-cycle gap and 3 cycles of backpressure.
    out_ready = 1'b0;
    send_beat(5'd5, 5'd9, 1'b0, 2'b00);
    send_beat(5'd3, 5'd7, 1'b1, 2'b01);
    min1_in = 5'd0; min2_in = 5'd0; cp_in = 1'b0; sgn_in = 2'b01;
    for (int i = 0; i < 2; i++) begin
      chk("gap.valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    send_beat(5'd4, 5'd6, 1'b0, 2'b00);
    send_beat(5'd8, 5'd12, 1'b1, 2'b10);
    // A beat offered during HOLD must be refused.
    in_valid = 1'b1; min1_in = 5'd0; min2_in = 5'd0; cp_in = 1'b1; sgn_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk_result("hold", 5'd3, 5'd4, 3'd3, 1'b0);
      @(negedge clk);
    end
    chk_result("hold_end", 5'd3, 5'd4, 3'd3, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold.release", 32'(out_valid), 32'd0);

    // Tie row: equal later minimum keeps the first index.
    send_beat(5'd2, 5'd9, 1'b0, 2'b00);
    send_beat(5'd2, 5'd3, 1'b1, 2'b00);
    send_beat(5'd7, 5'd8, 1'b0, 2'b00);
    send_beat(5'd7, 5'd8, 1'b0, 2'b00);
    chk_result("tie", 5'd2, 5'd2, 3'd0, 1'b0);
    @(negedge clk);

    // Odd sign and minimum at the last row position.
    send_beat(5'd6, 5'd7, 1'b0, 2'b01);
    send_beat(5'd6, 5'd7, 1'b1, 2'b00);
    send_beat(5'd10, 5'd11, 1'b1, 2'b00);
    send_beat(5'd1, 5'd2, 1'b1, 2'b00);
    chk_result("lastpos", 5'd1, 5'd2, 3'd7, 1'b1);
    @(negedge clk);

    // Reset mid-row discards the partial row.
    send_beat(5'd5, 5'd9, 1'b0, 2'b00);
    send_beat(5'd3, 5'd7, 1'b1, 2'b01);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.ready", 32'(in_ready), 32'd1);
    chk("midrst.min1", 32'(min1_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_beat(5'd1, 5'd2, 1'b0, 2'b11);
      chk("midrst.no_early", 32'(out_valid), 32'd0);
    end
    send_beat(5'd1, 5'd2, 1'b0, 2'b11);
    chk_result("midrst", 5'd1, 5'd1, 3'd0, 1'b0);
    @(negedge clk);

    // Zero-magnitude row (saturates to 0 in the offset build).
    send_beat(5'd0, 5'd1, 1'b0, 2'b00);
    send_beat(5'd5, 5'd6, 1'b0, 2'b00);
    send_beat(5'd5, 5'd6, 1'b1, 2'b00);
    send_beat(5'd9, 5'd9, 1'b0, 2'b00);
    chk_result("sat", 5'd0, 5'd1, 3'd0, 1'b0);

    // Reset while in HOLD drops the pending result.
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("holdrst.valid", 32'(out_valid), 32'd0);
    chk("holdrst.ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cn_min_accumulator.md
CN_MIN_ACCUMULATOR -- requirements
Module: cn_min_accumulator

Interface
REQ-001 Parameter W, default 6: message width including the sign bit; magnitudes are W-1 bits.
REQ-002 Parameter NBEATS, default 4: input beats per check row; row degree is 2*NBEATS.
REQ-003 Parameter IDXW, default 3: index width, equal to clog2(2*NBEATS).
REQ-004 Parameter OFFSET, default 1: offset-min-sum beta, W-1 bits.
REQ-005 clk  in  1  clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 min1_in  in  W-1  smaller magnitude of a registered 2-input min pair.
REQ-010 min2_in  in  W-1  larger magnitude of the same pair.
REQ-011 cp_in  in  1  position of min1_in within the pair: 0 = first input, 1 = second.
REQ-012 sgn_in  in  2  sign bits of the two messages in the pair.
REQ-013 out_valid  out  1  row result is valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 min1_out, min2_out  out  W-1  row minimum and second minimum.
REQ-016 idx_out  out  IDXW  row position of the minimum.
REQ-017 sgn_out  out  1  XOR of all 2*NBEATS sign bits in the row.

Function
REQ-018 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-019 The block has three states: IDLE, ACC and HOLD.
REQ-020 in_ready is 1 in IDLE and ACC and 0 in HOLD.
REQ-021 Beat counter cnt (0..NBEATS-1) gives the beat position; the position of a beat's minimum is {cnt, cp_in}.
REQ-022 First beat (cnt=0): the accumulator loads min1_in, min2_in, {0, cp_in} and sgn_in[0]^sgn_in[1] directly, with no merge.
REQ-023 Later beats merge as follows.
  - If min1_in < acc1: acc2 = min(acc1, min2_in); acc1 = min1_in; idx = {cnt, cp_in}.
  - Otherwise: acc2 = min(acc2, min1_in); acc1 and idx are unchanged.
REQ-024 Ties use strict less-than, so the earlier index is kept.
REQ-025 The sign accumulator XORs in sgn_in[0]^sgn_in[1] on every accepted beat.
REQ-026 State transitions:
  - IDLE goes to ACC on an accepted beat.
  - ACC stays in ACC and increments cnt on each accepted beat.
  - When beat NBEATS-1 is accepted, the state goes to HOLD and cnt wraps to 0.
  - If NBEATS=1, IDLE goes directly to HOLD.
REQ-027 out_valid is 1 exactly while in HOLD, starting the cycle after the last beat is accepted (latency 1 cycle).
REQ-028 min1_out, min2_out, idx_out and sgn_out stay stable while out_valid=1 and out_ready=0.
REQ-029 HOLD goes to IDLE on the edge where out_ready=1, so the next beat is accepted one cycle later.
REQ-030 Gaps in in_valid within a row are allowed; the accumulator and cnt hold their values across the gap.
REQ-031 When in_valid=0 the input data is ignored.
REQ-032 Magnitudes are unsigned; all compares are unsigned at W-1 bits, with no widening.

Reset
REQ-033 When rst=1 the block goes to IDLE and clears to 0: cnt, acc1, acc2, idx, sign and out_valid.
REQ-034 After reset in_ready=1 and min1_out, min2_out, idx_out and sgn_out are 0.
REQ-035 Reset mid-row or in HOLD discards the partial or pending row; no out_valid is produced for it.
REQ-036 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-037 With macro CNA_OFFSET_EN defined, OFFSET is subtracted from the min1_out and min2_out magnitudes with saturation at 0 (offset min-sum).
REQ-038 Without CNA_OFFSET_EN, min1_out and min2_out equal the accumulated magnitudes.
REQ-039 The macro affects only the output magnitudes; the accumulation, idx_out, sgn_out and timing are identical in both builds.

Verification (NBEATS=4, W=6, macro off unless stated)
REQ-040 Beats (m1,m2,cp,sgn): (5,9,0,00) (3,7,1,01) (4,6,0,00) (8,12,1,10), out_ready=1 -> one cycle after beat 4: out_valid=1, min1=3, min2=4, idx=3, sgn=0; in_ready=1 again two cycles after beat 4.
REQ-041 Tie: beats (2,9,0,00) (2,3,1,00) (7,8,0,00) (7,8,0,00) -> min1=2, min2=2, idx=0.
REQ-042 Gaps plus backpressure: the REQ-040 row with in_valid=0 for 2 cycles between beats 2 and 3, out_ready held 0 for 3 cycles -> out_valid and outputs stable for 3 cycles, in_ready=0, and a beat offered during HOLD is not accepted.
REQ-043 rst pulsed after beat 2 of a row, then a full new row (1,2,0,11)x4 -> only one result: min1=1, min2=1, idx=0, sgn=0.
REQ-044 CNA_OFFSET_EN, OFFSET=1: beats (0,1,0,00) (5,6,0,00) (5,6,1,00) (9,9,0,00) -> min1_out=0 (saturated), min2_out=0, idx=0.
